// File: rtl/sha3_pkg.sv
// Shared lane/row types and digest-length helpers for the SHA-3 output path.
package sha3_pkg;

    typedef logic [63:0] lane_t;
    typedef lane_t [4:0] row_t;

    localparam int unsigned NumLegalBits = 4;
    localparam logic [NumLegalBits-1:0][9:0] LegalDigestBits = {10'd512, 10'd384, 10'd256, 10'd224};

    // An unsupported length yields 0 lanes, which makes the lane vectors fail to elaborate.
    function automatic int unsigned digest_lanes(input int unsigned bits);
        int unsigned lanes;
        lanes = 0;
        for (int i = 0; i < NumLegalBits; i++) begin
            if (32'(LegalDigestBits[i[1:0]]) == bits) begin
                lanes = (bits + 63) / 64;
            end
        end
        return lanes;
    endfunction

endpackage

// File: rtl/sha3_digest_fifo.sv
// Slot FIFO of whole digests: DEPTH slots of LANES lanes each, pushed and freed one slot at a time.
module sha3_digest_fifo
    import sha3_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  lane_t [LANES-1:0]            i_wdata,
    input  logic                         i_pop,
    output lane_t [LANES-1:0]            o_rdata,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    lane_t [LANES-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_full;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    // A slot freed on this edge can take the incoming digest even when full.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/sha3_digest_serializer.sv
// Captures Keccak digest lanes on each sample strobe and streams them as 64-bit words.
// Define SHA3_DIGEST_BYTESWAP_EN for big-endian byte order per word (okeep mirrored).
module sha3_digest_serializer
    import sha3_pkg::*;
#(
    parameter int unsigned DIGEST_BITS = 256,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample,
    input  row_t                         rowa,
    input  row_t                         rowb,
    input  row_t                         rowc,
    input  row_t                         rowd,
    input  row_t                         rowe,
    output logic [63:0]                  odata,
    output logic                         ovalid,
    input  logic                         iready,
    output logic                         olast,
    output logic [7:0]                   okeep,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LANES        = digest_lanes(DIGEST_BITS);
    localparam int unsigned IDX_W        = $clog2(LANES);
    localparam bit          PARTIAL_LAST = (DIGEST_BITS % 64) != 0;

    lane_t [LANES-1:0] w_lanes;
    lane_t [LANES-1:0] w_slot;
    logic [IDX_W-1:0]  r_idx;
    logic              r_overflow;
    logic              w_empty;
    logic              w_drop;
    logic              w_beat;
    logic              w_last_word;
    logic              w_pop;
    lane_t             w_word;
    logic [7:0]        w_keep;
    logic              w_unused_rows;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k < 5) begin : g_rowa
            assign w_lanes[k] = rowa[k];
        end else begin : g_rowb
            assign w_lanes[k] = rowb[k-5];
        end
    end

    // Capacity rows and any lanes past the digest never reach the output.
    assign w_unused_rows = ^{rowa, rowb, rowc, rowd, rowe};

    sha3_digest_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (sample),
        .i_wdata (w_lanes),
        .i_pop   (w_pop),
        .o_rdata (w_slot),
        .o_empty (w_empty),
        .o_level (level),
        .o_drop  (w_drop)
    );

    assign ovalid      = ~w_empty;
    assign w_beat      = ovalid & iready;
    assign w_last_word = (r_idx == IDX_W'(LANES - 1));
    assign w_pop       = w_beat & w_last_word;
    assign overflow    = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_beat) begin
                r_idx <= w_last_word ? '0 : r_idx + IDX_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_word = w_slot[r_idx];
        w_keep = 8'hFF;
        if (PARTIAL_LAST && w_last_word) begin
            w_word[63:32] = '0;
            w_keep        = 8'h0F;
        end
    end

    always_comb begin
        odata = '0;
        okeep = '0;
        olast = 1'b0;
        if (ovalid) begin
            olast = w_last_word;
`ifdef SHA3_DIGEST_BYTESWAP_EN
            for (int b = 0; b < 8; b++) begin
                odata[8*b +: 8] = w_word[8*(7-b) +: 8];
                okeep[b]        = w_keep[7-b];
            end
`else
            odata = w_word;
            okeep = w_keep;
`endif
        end
    end

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Self-checking bench: vector table for 256/224/512 sequences plus a digest-queue reference model.
module tb_sha3_digest_serializer;
    import sha3_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    row_t        rowa, rowb, rowc, rowd, rowe;
    logic        samp [3];
    logic        rdy  [3];
    logic [63:0] od   [3];
    logic        ov   [3];
    logic        ol   [3];
    logic [7:0]  ok   [3];
    logic        ovf  [3];
    logic [2:0]  lvl  [3];

    sha3_digest_serializer #(.DIGEST_BITS(256), .DEPTH(DEPTH)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .sample(samp[0]), .rowa(rowa), .rowb(rowb), .rowc(rowc),
        .rowd(rowd), .rowe(rowe), .odata(od[0]), .ovalid(ov[0]), .iready(rdy[0]),
        .olast(ol[0]), .okeep(ok[0]), .overflow(ovf[0]), .level(lvl[0]));

    sha3_digest_serializer #(.DIGEST_BITS(224), .DEPTH(DEPTH)) u_dut224 (
        .clk(clk), .rst_n(rst_n), .sample(samp[1]), .rowa(rowa), .rowb(rowb), .rowc(rowc),
        .rowd(rowd), .rowe(rowe), .odata(od[1]), .ovalid(ov[1]), .iready(rdy[1]),
        .olast(ol[1]), .okeep(ok[1]), .overflow(ovf[1]), .level(lvl[1]));

    sha3_digest_serializer #(.DIGEST_BITS(512), .DEPTH(DEPTH)) u_dut512 (
        .clk(clk), .rst_n(rst_n), .sample(samp[2]), .rowa(rowa), .rowb(rowb), .rowc(rowc),
        .rowd(rowd), .rowe(rowe), .odata(od[2]), .ovalid(ov[2]), .iready(rdy[2]),
        .olast(ol[2]), .okeep(ok[2]), .overflow(ovf[2]), .level(lvl[2]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic lane_t exp_word(input lane_t raw);
        lane_t r;
        r = raw;
`ifdef SHA3_DIGEST_BYTESWAP_EN
        for (int b = 0; b < 8; b++) r[8*b +: 8] = raw[8*(7-b) +: 8];
`endif
        return r;
    endfunction

    function automatic logic [7:0] exp_keep(input bit partial);
        logic [7:0] k;
        k = partial ? 8'h0F : 8'hFF;
`ifdef SHA3_DIGEST_BYTESWAP_EN
        k = {<<{k}};
`endif
        return k;
    endfunction

    task automatic randomize_rows();
        for (int x = 0; x < 5; x++) begin
            rowa[x] = {$urandom, $urandom};
            rowb[x] = {$urandom, $urandom};
            rowc[x] = {$urandom, $urandom};
            rowd[x] = {$urandom, $urandom};
            rowe[x] = {$urandom, $urandom};
        end
    endtask

    // Reference model for the 256-bit instance: a queue of whole digests plus a word position.
    typedef logic [255:0] dig_t;
    dig_t mq [$];
    int   mpos;
    bit   movf;
    int   nbeats;

    task automatic model_clear();
        mq.delete();
        mpos = 0;
        movf = 1'b0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            samp[i] = 1'b0;
            rdy[i]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic mcheck();
        bit    v;
        lane_t w;
        v = (mq.size() > 0);
        chk("m_ovalid", 64'(ov[0]), 64'(v));
        chk("m_level", 64'(lvl[0]), 64'(mq.size()));
        chk("m_overflow", 64'(ovf[0]), 64'(movf));
        if (v) begin
            w = mq[0][64*mpos +: 64];
            chk("m_odata", od[0], exp_word(w));
            chk("m_olast", 64'(ol[0]), 64'(mpos == 3));
            chk("m_okeep", 64'(ok[0]), 64'(exp_keep(1'b0)));
        end else begin
            chk("m_odata_idle", od[0], 64'h0);
            chk("m_olast_idle", 64'(ol[0]), 64'h0);
            chk("m_okeep_idle", 64'(ok[0]), 64'h0);
        end
    endtask

    task automatic mstep(input bit s, input bit r);
        bit   beat, free, push_ok;
        dig_t cap, gone;
        samp[0] = s;
        rdy[0]  = r;
        cap     = {rowa[3], rowa[2], rowa[1], rowa[0]};
        beat    = (mq.size() > 0) && r;
        free    = beat && (mpos == 3);
        push_ok = s && ((mq.size() < DEPTH) || free);
        if (ov[0] && r) nbeats++;
        @(posedge clk);
        if (beat) begin
            if (free) begin
                gone = mq.pop_front();
                mpos = 0;
            end else begin
                mpos++;
            end
        end
        if (push_ok) mq.push_back(cap);
        if (s && !push_ok) movf = 1'b1;
        #1;
        mcheck();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && mq.size() > 0; c++) mstep(1'b0, 1'b1);
        chk("drain_done", 64'(ov[0]), 64'h0);
    endtask

    typedef struct {
        int         dut;
        bit         s;
        bit         r;
        bit         v;
        lane_t      data;
        bit         last;
        logic [7:0] keep;
        int         level;
    } vec_t;
    vec_t tv [$];

    task automatic add_seq(input int d, input int lanes, input bit partial);
        lane_t raw;
        bit    fin;
        for (int k = 0; k < lanes; k++) begin
            if (k < 5) raw = rowa[k];
            else       raw = rowb[k-5];
            fin = (k == lanes - 1);
            if (partial && fin) raw[63:32] = '0;
            tv.push_back('{dut: d, s: (k == 0), r: 1'b1, v: 1'b1, data: exp_word(raw),
                           last: fin, keep: exp_keep(partial && fin), level: 1});
        end
        tv.push_back('{dut: d, s: 1'b0, r: 1'b1, v: 1'b0, data: '0, last: 1'b0, keep: '0,
                       level: 0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int    pushed;
        bit    s, r;
        string nm;
        rst_n = 1'b0;
        randomize_rows();
        do_reset();

        for (int i = 0; i < 3; i++) begin
            nm = $sformatf("reset%0d", i);
            chk({nm, "_ovalid"}, 64'(ov[i]), 64'h0);
            chk({nm, "_odata"}, od[i], 64'h0);
            chk({nm, "_olast"}, 64'(ol[i]), 64'h0);
            chk({nm, "_okeep"}, 64'(ok[i]), 64'h0);
            chk({nm, "_overflow"}, 64'(ovf[i]), 64'h0);
            chk({nm, "_level"}, 64'(lvl[i]), 64'h0);
        end

        // SHA3-256("") lanes; the same rows feed the 224- and 512-bit sequences.
        rowa[0] = 64'h66d71ebff8c6ffa7;
        rowa[1] = 64'h62d661a05647c151;
        rowa[2] = 64'hfa493be44dff80f5;
        rowa[3] = 64'h4a43f8804b0ad882;
        add_seq(0, 4, 1'b0);
        add_seq(1, 4, 1'b1);
        add_seq(2, 8, 1'b0);
        foreach (tv[i]) begin
            int d;
            d = tv[i].dut;
            for (int j = 0; j < 3; j++) begin
                samp[j] = 1'b0;
                rdy[j]  = 1'b0;
            end
            samp[d] = tv[i].s;
            rdy[d]  = tv[i].r;
            @(posedge clk);
            #1;
            nm = $sformatf("tv%0d_dut%0d", i, d);
            chk({nm, "_ovalid"}, 64'(ov[d]), 64'(tv[i].v));
            chk({nm, "_odata"}, od[d], tv[i].data);
            chk({nm, "_olast"}, 64'(ol[d]), 64'(tv[i].last));
            chk({nm, "_okeep"}, 64'(ok[d]), 64'(tv[i].keep));
            chk({nm, "_level"}, 64'(lvl[d]), 64'(tv[i].level));
        end

        // Burst of DEPTH+1 samples with the sink stalled: the fifth is dropped.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            randomize_rows();
            mstep(1'b1, 1'b0);
        end
        chk("burst_level", 64'(lvl[0]), 64'd4);
        chk("burst_overflow", 64'(ovf[0]), 64'h1);
        nbeats = 0;
        drain(40);
        chk("burst_beats", 64'(nbeats), 64'd16);

        // Full FIFO, sample arrives on the head digest's final beat.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            randomize_rows();
            mstep(1'b1, 1'b0);
        end
        for (int n = 0; n < 3; n++) mstep(1'b0, 1'b1);
        randomize_rows();
        mstep(1'b1, 1'b1);
        chk("fullfree_level", 64'(lvl[0]), 64'd4);
        chk("fullfree_overflow", 64'(ovf[0]), 64'h0);
        nbeats = 0;
        drain(40);
        chk("fullfree_beats", 64'(nbeats), 64'd16);

        // Random backpressure over 100 digests, never offering a sample the model cannot hold.
        do_reset();
        pushed = 0;
        nbeats = 0;
        for (int c = 0; c < 4000 && (pushed < 100 || mq.size() > 0); c++) begin
            s = (pushed < 100) && (mq.size() < DEPTH) && ($urandom_range(0, 2) == 0);
            if (s) begin
                randomize_rows();
                pushed++;
            end
            r = ($urandom_range(0, 1) == 1);
            mstep(s, r);
        end
        chk("random_beats", 64'(nbeats), 64'd400);
        chk("random_overflow", 64'(ovf[0]), 64'h0);

        // Asynchronous reset while word 2 is on the bus.
        do_reset();
        randomize_rows();
        mstep(1'b1, 1'b1);
        mstep(1'b0, 1'b1);
        mstep(1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 64'(ov[0]), 64'h0);
        chk("midrst_odata", od[0], 64'h0);
        chk("midrst_olast", 64'(ol[0]), 64'h0);
        chk("midrst_okeep", 64'(ok[0]), 64'h0);
        chk("midrst_level", 64'(lvl[0]), 64'h0);
        samp[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        randomize_rows();
        mstep(1'b1, 1'b1);
        chk("postrst_word0", od[0], exp_word(rowa[0]));
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
